// File: rtl/omem_sched.sv
// ----------------------------------------------------------------------------
// omem_sched
//
// Purpose:
//   Scheduler in front of the single-port output memory. NUM_SPE SPEs request
//   either a store (potential+spike) or a fetch (previous-timestep residue).
//   Requests are granted round-robin, one transaction at a time. Each SPE owns
//   an interleaved address slice (SPE i writes i, i+NUM_SPE, ...). After
//   TOTAL stores a timestep is closed: a timestep-done packet is broadcast to
//   every destination PE, then the next timestep starts. After the last
//   timestep the block parks in DONE until reset.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready per-SPE request handshake, ready is a one-hot grant
//   req_op              per SPE: 0 = store, 1 = fetch
//   req_data            per SPE {potential, spike}, SPE i at [i*(SUM_WIDTH+1) +: SUM_WIDTH+1]
//   mem_en/we/bank/addr/wdata/rdata   single-port memory interface
//   rsp_valid/rsp_ready/rsp_id/rsp_data  fetch response channel
//   bcast_valid/bcast_ready/bcast_dest   timestep-done broadcast channel
//   ts_out              current timestep, 1-based
//   done                all timesteps complete (level)
//   err                 sticky, an out-of-range access was attempted
// ----------------------------------------------------------------------------
module omem_sched #(
    parameter int NUM_SPE     = 5,
    parameter int OUTPUT_SIZE = 21,
    parameter int NUM_TS      = 2,
    parameter int NUM_DEST    = 11,
    parameter int SUM_WIDTH   = 13
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SPE-1:0]             req_valid,
    output logic [NUM_SPE-1:0]             req_ready,
    input  logic [NUM_SPE-1:0]             req_op,
    input  logic [NUM_SPE*(SUM_WIDTH+1)-1:0] req_data,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [3:0]                     mem_bank,
    output logic [8:0]                     mem_addr,
    output logic [SUM_WIDTH:0]             mem_wdata,
    input  logic [SUM_WIDTH-1:0]           mem_rdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [2:0]                     rsp_id,
    output logic [SUM_WIDTH-1:0]           rsp_data,
    output logic                           bcast_valid,
    input  logic                           bcast_ready,
    output logic [3:0]                     bcast_dest,
    output logic [3:0]                     ts_out,
    output logic                           done,
    output logic                           err
);

    localparam int         TOTAL     = OUTPUT_SIZE * OUTPUT_SIZE;
    localparam int         DW        = SUM_WIDTH + 1;
    localparam logic [8:0] TOTAL_C   = 9'(TOTAL);
    localparam logic [8:0] STEP_C    = 9'(NUM_SPE);
    localparam logic [2:0] LAST_SPE  = 3'(NUM_SPE - 1);
    localparam logic [3:0] LAST_DEST = 4'(NUM_DEST - 1);
    localparam logic [3:0] LAST_TS   = 4'(NUM_TS);

    typedef enum logic [2:0] {
        S_ARB,
        S_EXEC,
        S_RDWAIT,
        S_RSP,
        S_BCAST,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [2:0]                 id_q, id_d;
    logic                       op_q, op_d;
    logic [DW-1:0]              data_q, data_d;
    logic [2:0]                 rr_last_q, rr_last_d;
    logic [NUM_SPE-1:0][8:0]    ptr_q, ptr_d;
    logic [8:0]                 store_cnt_q, store_cnt_d;
    logic [3:0]                 ts_q, ts_d;
    logic [3:0]                 dest_q, dest_d;
    logic [SUM_WIDTH-1:0]       rsp_data_q, rsp_data_d;
    logic [2:0]                 rsp_id_q, rsp_id_d;
    logic                       err_q, err_d;
    logic                       fetch_zero_q, fetch_zero_d;

    logic                       grant_found;
    logic [2:0]                 grant_id;
    logic [8:0]                 cur_ptr;
    logic                       in_range;

    // Round-robin search: scan the SPEs starting just after the last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int off = 1; off <= NUM_SPE; off++) begin
            if (!grant_found && req_valid[(int'(rr_last_q) + off) % NUM_SPE]) begin
                grant_found = 1'b1;
                grant_id    = 3'((int'(rr_last_q) + off) % NUM_SPE);
            end
        end
    end

    // The grant is only offered while arbitrating; other states leave requests pending.
    always_comb begin
        req_ready = '0;
        if (state_q == S_ARB && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign cur_ptr  = ptr_q[id_q];
    assign in_range = (cur_ptr < TOTAL_C);

    // Next-state logic for the scheduler and all its bookkeeping registers.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        op_d         = op_q;
        data_d       = data_q;
        rr_last_d    = rr_last_q;
        ptr_d        = ptr_q;
        store_cnt_d  = store_cnt_q;
        ts_d         = ts_q;
        dest_d       = dest_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        err_d        = err_q;
        fetch_zero_d = fetch_zero_q;

        case (state_q)
            S_ARB: begin
                if (grant_found) begin
                    id_d      = grant_id;
                    op_d      = req_op[grant_id];
                    data_d    = req_data[int'(grant_id)*DW +: DW];
                    rr_last_d = grant_id;
                    state_d   = S_EXEC;
                end
            end

            S_EXEC: begin
                if (!in_range) begin
                    err_d = 1'b1;
                    if (op_q) begin
                        fetch_zero_d = 1'b1;
                        state_d      = S_RDWAIT;
                    end else begin
                        state_d = S_ARB;
                    end
                end else if (!op_q) begin
                    ptr_d[id_q] = cur_ptr + STEP_C;
                    store_cnt_d = store_cnt_q + 9'd1;
                    if (store_cnt_q + 9'd1 == TOTAL_C) begin
                        state_d = (ts_q == LAST_TS) ? S_DONE : S_BCAST;
                    end else begin
                        state_d = S_ARB;
                    end
                end else begin
                    // Timestep 1 has no previous residue, so the answer is zero
                    // but still travels through RDWAIT to keep fetch latency uniform.
                    fetch_zero_d = (ts_q == 4'd1);
                    state_d      = S_RDWAIT;
                end
            end

            S_RDWAIT: begin
                rsp_data_d = fetch_zero_q ? '0 : mem_rdata;
                rsp_id_d   = id_q;
                state_d    = S_RSP;
            end

            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_ARB;
                end
            end

            S_BCAST: begin
                if (bcast_ready) begin
                    if (dest_q == LAST_DEST) begin
                        dest_d      = '0;
                        ts_d        = ts_q + 4'd1;
                        store_cnt_d = '0;
                        for (int i = 0; i < NUM_SPE; i++) begin
                            ptr_d[i] = 9'(i);
                        end
                        state_d = S_ARB;
                    end else begin
                        dest_d = dest_q + 4'd1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_DONE;
            end

            default: begin
                state_d = S_ARB;
            end
        endcase
    end

    // State registers; reset drops any in-flight transaction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_ARB;
            id_q         <= '0;
            op_q         <= 1'b0;
            data_q       <= '0;
            rr_last_q    <= LAST_SPE;
            for (int i = 0; i < NUM_SPE; i++) begin
                ptr_q[i] <= 9'(i);
            end
            store_cnt_q  <= '0;
            ts_q         <= 4'd1;
            dest_q       <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            err_q        <= 1'b0;
            fetch_zero_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            op_q         <= op_d;
            data_q       <= data_d;
            rr_last_q    <= rr_last_d;
            ptr_q        <= ptr_d;
            store_cnt_q  <= store_cnt_d;
            ts_q         <= ts_d;
            dest_q       <= dest_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            err_q        <= err_d;
            fetch_zero_q <= fetch_zero_d;
        end
    end

    // Output decode from registered state only; memory fields are zeroed when idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_bank  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == S_EXEC && in_range) begin
            if (!op_q) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_bank  = ts_q - 4'd1;
                mem_addr  = cur_ptr;
                mem_wdata = data_q;
            end else if (ts_q != 4'd1) begin
                mem_en   = 1'b1;
                mem_bank = ts_q - 4'd2;
                mem_addr = cur_ptr;
            end
        end
    end

    assign rsp_valid   = (state_q == S_RSP);
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign bcast_valid = (state_q == S_BCAST);
    assign bcast_dest  = dest_q;
    assign ts_out      = ts_q;
    assign done        = (state_q == S_DONE);
    assign err         = err_q;

endmodule

// File: tb/tb_omem_sched.sv
// ----------------------------------------------------------------------------
// tb_omem_sched
//
// Directed bench for omem_sched with a small behavioural memory that returns
// the stored potential as the residue one cycle after a read.
// ----------------------------------------------------------------------------
module tb_omem_sched;

    localparam int NSPE = 5;
    localparam int DW   = 14;

    logic                 clk;
    logic                 rst_n;
    logic [NSPE-1:0]      req_valid;
    logic [NSPE-1:0]      req_ready;
    logic [NSPE-1:0]      req_op;
    logic [NSPE*DW-1:0]   req_data;
    logic                 mem_en;
    logic                 mem_we;
    logic [3:0]           mem_bank;
    logic [8:0]           mem_addr;
    logic [13:0]          mem_wdata;
    logic [12:0]          mem_rdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2:0]           rsp_id;
    logic [12:0]          rsp_data;
    logic                 bcast_valid;
    logic                 bcast_ready;
    logic [3:0]           bcast_dest;
    logic [3:0]           ts_out;
    logic                 done;
    logic                 err;

    int checks;
    int errors;

    omem_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_data   (req_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_bank   (mem_bank),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .bcast_valid(bcast_valid),
        .bcast_ready(bcast_ready),
        .bcast_dest (bcast_dest),
        .ts_out     (ts_out),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model plus write bookkeeping per bank (banks 0 and 1 only).
    logic [12:0] tbMem [0:3][0:511];
    logic        seen0 [0:511];
    int          writes0;
    int          writes1;
    int          distinct0;

    always @(posedge clk) begin
        if (!rst_n) begin
            writes0   = 0;
            writes1   = 0;
            distinct0 = 0;
            for (int a = 0; a < 512; a++) seen0[a] = 1'b0;
        end else if (mem_en && mem_we) begin
            tbMem[mem_bank[1:0]][mem_addr] <= mem_wdata[13:1];
            if (mem_bank == 4'd0) begin
                writes0++;
                if (!seen0[mem_addr]) begin
                    seen0[mem_addr] = 1'b1;
                    distinct0++;
                end
            end else begin
                writes1++;
            end
        end else if (mem_en) begin
            mem_rdata <= tbMem[mem_bank[1:0]][mem_addr];
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NSPE-1:0] valid, input logic [NSPE-1:0] op);
        req_valid = valid;
        req_op    = op;
    endtask

    task automatic setData(input int spe, input logic [12:0] pot, input logic spk);
        req_data[spe*DW +: DW] = {pot, spk};
    endtask

    // Waits (from a negedge) for any grant; leaves the caller at the sampling point.
    task automatic waitAnyGrant(input int budget, output logic [NSPE-1:0] g);
        bit ok;
        ok = 1'b0;
        g  = '0;
        for (int n = 0; n < budget; n++) begin
            #1;
            if (req_ready != '0) begin
                g  = req_ready;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) checkOutput("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n       = 1'b0;
        req_valid   = '0;
        req_op      = '0;
        req_data    = '0;
        rsp_ready   = 1'b0;
        bcast_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [NSPE-1:0] g;
    int              expGrant [3];
    bit              seenEvent;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;

        // Reset values
        doReset();
        checkOutput("reset_ts_out", 32'(ts_out), 32'd1);
        checkOutput("reset_outputs",
                    32'({req_ready, mem_en, mem_we, rsp_valid, bcast_valid, done, err}), 32'd0);

        // Two SPE0 stores: addresses 0 then 5 in bank 0
        setData(0, 13'd100, 1'b1);
        applyStimulus(5'b00001, 5'b00000);
        waitAnyGrant(10, g);
        checkOutput("first_grant", 32'(g), 32'b00001);
        @(negedge clk);
        checkOutput("store0_en_we", 32'({mem_en, mem_we}), 32'b11);
        checkOutput("store0_addr", 32'(mem_addr), 32'd0);
        checkOutput("store0_bank", 32'(mem_bank), 32'd0);
        checkOutput("store0_wdata", 32'(mem_wdata), 32'd201);
        checkOutput("exec_ready_low", 32'(req_ready), 32'd0);
        applyStimulus(5'b00000, 5'b00000);
        @(negedge clk);
        applyStimulus(5'b00001, 5'b00000);
        waitAnyGrant(10, g);
        @(negedge clk);
        applyStimulus(5'b00000, 5'b00000);
        checkOutput("store1_addr", 32'(mem_addr), 32'd5);

        // Round-robin order among SPE1,3,4, then wrap to SPE0
        doReset();
        expGrant = '{1, 3, 4};
        applyStimulus(5'b11010, 5'b00000);
        for (int i = 0; i < 3; i++) begin
            waitAnyGrant(10, g);
            checkOutput("rr_grant", 32'(g), 32'(1) << expGrant[i]);
            @(negedge clk);
        end
        applyStimulus(5'b00011, 5'b00000);
        waitAnyGrant(10, g);
        checkOutput("rr_wrap", 32'(g), 32'b00001);
        @(negedge clk);
        applyStimulus(5'b00000, 5'b00000);

        // Fetch in timestep 1: zero answer, no memory access, reset during RSP
        doReset();
        applyStimulus(5'b00100, 5'b00100);
        waitAnyGrant(10, g);
        @(negedge clk);
        applyStimulus(5'b00000, 5'b00000);
        checkOutput("ts1_fetch_exec", 32'({mem_en, rsp_valid}), 32'd0);
        @(negedge clk);
        checkOutput("ts1_fetch_wait", 32'({mem_en, rsp_valid}), 32'd0);
        @(negedge clk);
        checkOutput("ts1_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("ts1_rsp_id", 32'(rsp_id), 32'd2);
        checkOutput("ts1_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        checkOutput("rsp_hold", 32'({rsp_valid, rsp_id}), 32'b1010);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("async_reset_ts", 32'(ts_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Full timestep 1 of stores, then the broadcast
        doReset();
        for (int s = 0; s < NSPE; s++) setData(s, (s == 0) ? 13'd77 : 13'(s), 1'b0);
        bcast_ready = 1'b1;
        applyStimulus(5'b11111, 5'b00000);
        seenEvent = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (bcast_valid) begin
                seenEvent = 1'b1;
                break;
            end
        end
        applyStimulus(5'b00000, 5'b00000);
        checkOutput("ts1_reach_bcast", 32'(seenEvent), 32'd1);
        checkOutput("ts1_writes", 32'(writes0), 32'd441);
        checkOutput("ts1_distinct", 32'(distinct0), 32'd441);
        for (int k = 0; k < 11; k++) begin
            if (k == 4) begin
                bcast_ready = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    checkOutput("bcast_hold", 32'({bcast_valid, bcast_dest}), 32'h14);
                end
                bcast_ready = 1'b1;
            end
            checkOutput("bcast_dest", 32'({bcast_valid, bcast_dest}), 32'h10 | 32'(k));
            @(negedge clk);
        end
        checkOutput("after_bcast_valid", 32'(bcast_valid), 32'd0);
        checkOutput("after_bcast_ts", 32'(ts_out), 32'd2);

        // Timestep 2: fetch SPE0 residue from bank 0 addr 0
        applyStimulus(5'b00001, 5'b00001);
        waitAnyGrant(10, g);
        checkOutput("ts2_fetch_grant", 32'(g), 32'b00001);
        @(negedge clk);
        applyStimulus(5'b00000, 5'b00000);
        checkOutput("ts2_read_ctrl", 32'({mem_en, mem_we}), 32'b10);
        checkOutput("ts2_read_bank", 32'(mem_bank), 32'd0);
        checkOutput("ts2_read_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("ts2_rsp", 32'({rsp_valid, rsp_id, rsp_data}), {16'd0, 1'b1, 3'd0, 13'd77});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_accepted", 32'(rsp_valid), 32'd0);

        // Timestep 2 stores until done
        applyStimulus(5'b00001, 5'b00000);
        waitAnyGrant(10, g);
        @(negedge clk);
        checkOutput("ts2_store_addr", 32'(mem_addr), 32'd0);
        checkOutput("ts2_store_bank", 32'(mem_bank), 32'd1);
        applyStimulus(5'b11111, 5'b00000);
        seenEvent = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (done) begin
                seenEvent = 1'b1;
                break;
            end
        end
        checkOutput("ts2_done", 32'(seenEvent), 32'd1);
        checkOutput("ts2_writes", 32'(writes1), 32'd441);
        @(negedge clk);
        #1;
        checkOutput("done_no_grant", 32'({done, req_ready}), 32'b100000);
        checkOutput("done_err_clear", 32'(err), 32'd0);
        applyStimulus(5'b00000, 5'b00000);

        // SPE0 runs past its slice: the 90th store is refused and flags err
        doReset();
        setData(0, 13'd5, 1'b1);
        applyStimulus(5'b00001, 5'b00000);
        for (int i = 0; i < 90; i++) begin
            waitAnyGrant(10, g);
            @(negedge clk);
            if (i == 88) checkOutput("last_valid_addr", 32'({mem_we, mem_addr}), 32'h3B8);
            if (i == 89) begin
                applyStimulus(5'b00000, 5'b00000);
                checkOutput("oob_no_write", 32'({mem_en, mem_we}), 32'd0);
                checkOutput("oob_err_before", 32'(err), 32'd0);
            end
        end
        @(negedge clk);
        checkOutput("oob_err", 32'(err), 32'd1);
        checkOutput("oob_writes", 32'(writes0), 32'd89);
        @(negedge clk);
        checkOutput("err_sticky", 32'(err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
